// File: rtl/risc_fetch_queue_if.sv
// rtl/risc_fetch_queue_if.sv - fetch front end memory, redirect and decode handshake bundle
interface risc_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int IW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Instruction memory request and one-cycle-later read data
    logic              IREQ;
    logic [XLEN-3:0]   IADDR;
    logic [IW-1:0]     INSTR;

    // Branch/jump resolution from execute
    logic              REDIR;
    logic [XLEN-1:0]   REDIR_PC;

    // Queue head toward decode
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [IW-1:0]     OUT_INSTR;
    logic [XLEN-1:0]   OUT_PC;
    logic [CW-1:0]     COUNT;

    // Environment side: memory, execute and decode
    modport master (
        output INSTR, REDIR, REDIR_PC, OUT_READY,
        input  IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_PC, COUNT
    );

    // Fetch front end side
    modport slave (
        input  INSTR, REDIR, REDIR_PC, OUT_READY,
        output IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_PC, COUNT
    );
endinterface

// File: rtl/risc_fetch_queue.sv
// rtl/risc_fetch_queue.sv - PC generator, credit-limited fetch and {PC, instr} queue with redirect flush
module risc_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RSTN,
    risc_fetch_queue_if.slave bus
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_PC_W = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [CW:0]     DEPTH_C    = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   FULL_C     = CW'(DEPTH);

    // Fetch state
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;

    // Circular queue state
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [IW-1:0]   r_q_instr [DEPTH];

    // Head values shown to decode once the queue runs empty
    logic [XLEN-1:0] r_last_pc;
    logic [IW-1:0]   r_last_instr;

    logic            w_ireq;
    logic            w_push;
    logic            w_pop;
    logic            w_out_valid;
    logic            w_nonempty;
    logic [CW:0]     w_credits_used;

    // Credit check counts the in-flight word so a response always has a free slot
    always_comb begin
        w_credits_used = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
        w_nonempty     = (r_count != '0);
        w_ireq         = RSTN && !bus.REDIR && (w_credits_used < DEPTH_C);
        w_out_valid    = w_nonempty && !bus.REDIR;
        w_push         = r_inflight && !bus.REDIR;
        w_pop          = w_out_valid && bus.OUT_READY;
    end

    assign bus.IREQ      = w_ireq;
    assign bus.IADDR     = r_fetch_pc[XLEN-1:2];
    assign bus.OUT_VALID = w_out_valid;
    assign bus.OUT_PC    = w_nonempty ? r_q_pc[r_head]    : r_last_pc;
    assign bus.OUT_INSTR = w_nonempty ? r_q_instr[r_head] : r_last_instr;
    assign bus.COUNT     = r_count;

    // PC generation, in-flight tracking, queue pointers; redirect overrides everything
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_fetch_pc    <= RESET_PC_W;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_last_pc     <= '0;
            r_last_instr  <= '0;
        end else if (bus.REDIR) begin
            r_fetch_pc <= {bus.REDIR_PC[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_ireq) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + PC_STEP;
            end else begin
                r_inflight <= 1'b0;
            end

            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end

            if (w_pop) begin
                r_head       <= r_head + PW'(1);
                r_last_pc    <= r_q_pc[r_head];
                r_last_instr <= r_q_instr[r_head];
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; only slots between head and tail are ever read
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_inflight_pc;
            r_q_instr[r_tail] <= bus.INSTR;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(w_push && (r_count == FULL_C)));

endmodule

// File: tb/tb_risc_fetch_queue.sv
// tb/tb_risc_fetch_queue.sv - directed scoreboard bench for risc_fetch_queue
module tb_risc_fetch_queue;

    logic CLK = 1'b0;
    logic RSTN;

    risc_fetch_queue_if #(.XLEN(32), .IW(32), .DEPTH(4)) bus ();

    risc_fetch_queue #(
        .XLEN(32), .IW(32), .DEPTH(4), .RESET_PC(32'h100)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: data is the word address, returned one cycle later
    always @(posedge CLK) bus.INSTR <= {2'b00, bus.IADDR};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    // Scoreboard compare on every accepted head, then advance to the next negedge
    task automatic next();
        logic [31:0] e;
        if (bus.OUT_VALID && bus.OUT_READY) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_pop: observed pc 0x%0h expected none", bus.OUT_PC);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", 64'(bus.OUT_PC), 64'(e));
                chk("out_instr", 64'(bus.OUT_INSTR), 64'(e >> 2));
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            next();
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            #1;
            next();
            k++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    logic exp_ireq [6];

    initial begin
        exp_ireq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        RSTN          = 1'b0;
        bus.REDIR     = 1'b0;
        bus.REDIR_PC  = '0;
        bus.OUT_READY = 1'b1;
        @(negedge CLK);

        // Reset values
        #1;
        chk("rst_ireq", 64'(bus.IREQ), 64'd0);
        chk("rst_iaddr", 64'(bus.IADDR), 64'h40);
        chk("rst_ovalid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_opc", 64'(bus.OUT_PC), 64'd0);
        chk("rst_oinstr", 64'(bus.OUT_INSTR), 64'd0);
        chk("rst_count", 64'(bus.COUNT), 64'd0);
        next();

        // Stream from RESET_PC, one per cycle from c2
        RSTN = 1'b1;
        push_seq(32'h100, 8);
        #1;
        chk("c0_ireq", 64'(bus.IREQ), 64'd1);
        chk("c0_iaddr", 64'(bus.IADDR), 64'h40);
        chk("c0_ovalid", 64'(bus.OUT_VALID), 64'd0);
        next();
        #1;
        chk("c1_ovalid", 64'(bus.OUT_VALID), 64'd0);
        next();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("stream_ovalid", 64'(bus.OUT_VALID), 64'd1);
            next();
        end
        chk("stream_drained", 64'(sb.size()), 64'd0);
        bus.OUT_READY = 1'b0;

        // Backpressure from PC 0
        bus.REDIR = 1'b1;
        bus.REDIR_PC = 32'h0;
        #1;
        chk("bp_redir_ireq", 64'(bus.IREQ), 64'd0);
        next();
        bus.REDIR = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_ireq", 64'(bus.IREQ), 64'(exp_ireq[i]));
            if (i == 0) chk("bp_iaddr", 64'(bus.IADDR), 64'h0);
            if (i == 5) chk("bp_count_full", 64'(bus.COUNT), 64'd4);
            next();
        end
        push_seq(32'h0, 8);
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("bp_drain_ovalid", 64'(bus.OUT_VALID), 64'd1);
            next();
        end
        chk("bp_drained", 64'(sb.size()), 64'd0);
        bus.OUT_READY = 1'b0;

        // Redirect with COUNT=3 and a fetch in flight
        bus.REDIR = 1'b1;
        bus.REDIR_PC = 32'h300;
        #1;
        next();
        bus.REDIR = 1'b0;
        idle(4);
        bus.REDIR = 1'b1;
        bus.REDIR_PC = 32'h203;
        #1;
        chk("rd_count_pre", 64'(bus.COUNT), 64'd3);
        chk("rd_ovalid_pre", 64'(bus.OUT_VALID), 64'd0);
        next();
        bus.REDIR = 1'b0;
        bus.OUT_READY = 1'b1;
        push_seq(32'h200, 4);
        #1;
        chk("rd_count_post", 64'(bus.COUNT), 64'd0);
        chk("rd_iaddr", 64'(bus.IADDR), 64'h80);
        chk("rd_ireq", 64'(bus.IREQ), 64'd1);
        next();
        #1;
        chk("rd_r2_ovalid", 64'(bus.OUT_VALID), 64'd0);
        next();
        #1;
        chk("rd_r3_ovalid", 64'(bus.OUT_VALID), 64'd1);
        next();
        drain("rd_drained", 12);
        bus.OUT_READY = 1'b0;

        // Redirect held for three cycles
        for (int i = 0; i < 3; i++) begin
            bus.REDIR = 1'b1;
            bus.REDIR_PC = 32'(32'h40 * (i + 1));
            #1;
            chk("hold_ireq", 64'(bus.IREQ), 64'd0);
            chk("hold_ovalid", 64'(bus.OUT_VALID), 64'd0);
            next();
        end
        bus.REDIR = 1'b0;
        bus.OUT_READY = 1'b1;
        push_seq(32'hC0, 4);
        #1;
        chk("hold_iaddr", 64'(bus.IADDR), 64'h30);
        chk("hold_resume_ireq", 64'(bus.IREQ), 64'd1);
        next();
        drain("hold_drained", 12);
        bus.OUT_READY = 1'b0;

        // PC wrap
        bus.REDIR = 1'b1;
        bus.REDIR_PC = 32'hFFFF_FFFC;
        #1;
        next();
        bus.REDIR = 1'b0;
        bus.OUT_READY = 1'b1;
        push_seq(32'hFFFF_FFFC, 4);
        #1;
        chk("wrap_iaddr", 64'(bus.IADDR), 64'h3FFF_FFFF);
        next();
        drain("wrap_drained", 12);
        bus.OUT_READY = 1'b0;

        // Asynchronous reset mid-stream with COUNT=2 and a fetch in flight
        bus.REDIR = 1'b1;
        bus.REDIR_PC = 32'h500;
        #1;
        next();
        bus.REDIR = 1'b0;
        idle(3);
        #1;
        chk("mr_count_pre", 64'(bus.COUNT), 64'd2);
        chk("mr_ireq_pre", 64'(bus.IREQ), 64'd1);
        #1;
        RSTN = 1'b0;
        #1;
        chk("mr_ireq", 64'(bus.IREQ), 64'd0);
        chk("mr_iaddr", 64'(bus.IADDR), 64'h40);
        chk("mr_ovalid", 64'(bus.OUT_VALID), 64'd0);
        chk("mr_opc", 64'(bus.OUT_PC), 64'd0);
        chk("mr_oinstr", 64'(bus.OUT_INSTR), 64'd0);
        chk("mr_count", 64'(bus.COUNT), 64'd0);
        next();
        idle(1);
        RSTN = 1'b1;
        bus.OUT_READY = 1'b1;
        push_seq(32'h100, 4);
        #1;
        chk("mr_c0_ireq", 64'(bus.IREQ), 64'd1);
        chk("mr_c0_iaddr", 64'(bus.IADDR), 64'h40);
        next();
        drain("mr_drained", 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_fetch_queue.md
# risc_fetch_queue

Parametrised instruction-fetch front end for the RISC_TOY core family. It replaces the single-register fetch stage with three parts:
- a PC generator,
- a credit-limited request path to instruction memory,
- a DEPTH-entry {PC, instruction} queue with a valid/ready handshake toward decode.

A redirect input (branch/jump resolution) flushes the queue and discards the in-flight fetch, so decode only ever sees correct-path instructions.

## Interface
Parameters:
- XLEN, 32, PC width in bits; IADDR is the word address PC[XLEN-1:2].
- IW, 32, instruction width in bits.
- DEPTH, 4, number of queue entries; power of two, ≥2.
- RESET_PC, 0, PC loaded on reset; bits [1:0] are ignored (treated as 0).

Ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- IREQ  out  1  fetch request to instruction memory this cycle.
- IADDR  out  XLEN-2  word address of the request.
- INSTR  in  IW  memory read data; valid exactly one cycle after the cycle IREQ was high.
- REDIR  in  1  redirect/flush request from execute.
- REDIR_PC  in  XLEN  new fetch PC; bits [1:0] are forced to 0.
- OUT_VALID  out  1  the queue head is presented to decode.
- OUT_READY  in  1  decode accepts the head this cycle.
- OUT_INSTR  out  IW  instruction at the queue head.
- OUT_PC  out  XLEN  byte PC of the head instruction.
- COUNT  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
State:
- fetch_pc (XLEN).
- inflight flag plus inflight_pc (XLEN).
- Circular queue: head pointer, tail pointer, count.

Request path:
- IREQ = !REDIR && (count + inflight < DEPTH). Combinational from registered state and REDIR.
- IADDR = fetch_pc[XLEN-1:2] at all times, including when IREQ = 0.
- On an edge where IREQ = 1: inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (wraps modulo 2^XLEN). Otherwise inflight ← 0.

Response path:
- On an edge where inflight = 1 and REDIR = 0, {inflight_pc, INSTR} is written at the tail; tail and count increment.
- The credit rule makes overflow impossible. A push into a full queue is a design error, checked by an assertion.

Output path:
- OUT_VALID = (count ≠ 0) && !REDIR.
- OUT_INSTR / OUT_PC come from the head entry. When count = 0 they hold the last popped values (0 after reset).
- Pop happens on an edge where OUT_VALID && OUT_READY: head increments, count decrements.
- Simultaneous push and pop leaves count unchanged. Pointers wrap at DEPTH.

Redirect (edge with REDIR = 1):
- Queue emptied: head = tail = count = 0.
- inflight ← 0; the INSTR arriving this cycle is dropped.
- fetch_pc ← {REDIR_PC[XLEN-1:2], 2'b00}.
- No push and no pop occur on this edge; OUT_READY is ignored.
- REDIR held high for several cycles: each cycle re-flushes and reloads fetch_pc; IREQ stays 0 throughout.

Reset (RSTN low, at any time including mid-fetch):
- fetch_pc = RESET_PC & ~3, inflight = 0, queue empty.
- IREQ = 0 while RSTN is low; IADDR = RESET_PC[XLEN-1:2].
- OUT_VALID = 0, OUT_INSTR = 0, OUT_PC = 0, COUNT = 0.
- Any memory response after reset release is ignored because inflight = 0.

## Timing
- Reset release: IREQ = 1 in the first cycle (c0) with IADDR = RESET_PC>>2. INSTR returns in c1 and is pushed at the end of c1. OUT_VALID = 1 in c2.
- Redirect latency: REDIR in cycle r → IREQ for REDIR_PC in r+1 → OUT_VALID with OUT_PC = REDIR_PC in r+3.
- Throughput with OUT_READY held high:
  - DEPTH ≥ 3: one instruction per cycle in steady state.
  - DEPTH = 2: one instruction every other cycle.
- Backpressure: with OUT_READY held low, IREQ deasserts once count + inflight = DEPTH. No instruction is lost or duplicated.
- No combinational path from OUT_READY to IREQ.
- Paths from REDIR to IREQ and OUT_VALID are combinational.

## Test plan
- Reset, RESET_PC = 0x100, memory returns word-address-as-data, OUT_READY = 1:
  - OUT_VALID first rises in c2 with OUT_PC = 0x100, OUT_INSTR = 0x40.
  - Consecutive OUT_PC values 0x104, 0x108, … follow, one per cycle.
- DEPTH = 4, OUT_READY = 0:
  - IREQ high for exactly 4 cycles, then low; COUNT = 4.
  - Raise OUT_READY: entries drain in order 0x0, 0x4, 0x8, 0xC, then streaming resumes at 0x10 with no gap or duplicate.
- REDIR = 1 with REDIR_PC = 0x203 while COUNT = 3 and inflight = 1:
  - Next cycle COUNT = 0 and IADDR = 0x80.
  - First OUT_PC after the flush is 0x200; no old-path PC ever appears.
- REDIR held for 3 cycles with changing REDIR_PC (0x40, 0x80, 0xC0):
  - IREQ = 0 for all 3 cycles.
  - Fetch resumes at 0xC0 only.
- fetch_pc = 0xFFFFFFFC, XLEN = 32:
  - Next fetched OUT_PC sequence is 0xFFFFFFFC then 0x00000000.
- RSTN pulsed low mid-stream with COUNT = 2 and inflight = 1:
  - All outputs immediately take reset values.
  - After release, the stream restarts at RESET_PC.
